// File: rtl/dpd_poly_5.sv
// Five-stage memory-polynomial predistorter: y = x * sum(c_k * |x|^k).
// Coefficients are double-buffered (shadow/active) so that a bank change lands on one sample boundary.
module dpd_poly_5 #(
  parameter int SIG_DLY = 4
) (
  input  logic               clk,
  input  logic               reset_b,
  input  logic signed [19:0] sig_in_i,
  input  logic signed [19:0] sig_in_q,
  input  logic               in_valid,
  input  logic        [19:0] mag_0,
  input  logic        [19:0] mag_1,
  input  logic        [19:0] mag_2,
  input  logic        [19:0] mag_3,
  input  logic        [19:0] mag_4,
  input  logic               coef_we,
  input  logic        [2:0]  coef_addr,
  input  logic signed [17:0] coef_i,
  input  logic signed [17:0] coef_q,
  input  logic               coef_swap,
  output logic signed [19:0] sig_out_i,
  output logic signed [19:0] sig_out_q,
  output logic               out_valid,
  output logic        [15:0] sat_cnt,
  input  logic               sat_clr
);

  localparam logic signed [17:0] UNITY = 18'sd16384;

  logic signed [17:0] shadowI_q [5];
  logic signed [17:0] shadowQ_q [5];
  logic signed [17:0] shadowI_d [5];
  logic signed [17:0] shadowQ_d [5];
  logic signed [17:0] activeI_q [5];
  logic signed [17:0] activeQ_q [5];
  logic        [19:0] mag [5];

  logic signed [19:0] dlyI_q [SIG_DLY];
  logic signed [19:0] dlyQ_q [SIG_DLY];
  logic               dlyV_q [SIG_DLY];
  logic signed [19:0] xI1_q, xQ1_q, xI2_q, xQ2_q, xI3_q, xQ3_q;
  logic               v1_q, v2_q, v3_q, v4_q, outValid_q;

  logic signed [37:0] prodI_d [5];
  logic signed [37:0] prodQ_d [5];
  logic signed [37:0] prodI_q [5];
  logic signed [37:0] prodQ_q [5];
  logic signed [40:0] accI_d, accQ_d, accI_q, accQ_q;
  logic signed [17:0] gI_q, gQ_q;
  logic signed [37:0] pII_q, pQQ_q, pIQ_q, pQI_q;
  logic signed [39:0] sumI, sumQ, shI, shQ;
  logic               satI, satQ;
  logic signed [19:0] yI_d, yQ_d, yI_q, yQ_q;
  logic        [15:0] satCnt_q;

  assign mag[0] = mag_0;
  assign mag[1] = mag_1;
  assign mag[2] = mag_2;
  assign mag[3] = mag_3;
  assign mag[4] = mag_4;

  // A swap copies the shadow bank including a write made in the same cycle.
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      shadowI_d[k] = shadowI_q[k];
      shadowQ_d[k] = shadowQ_q[k];
      if (coef_we && (coef_addr == 3'(k))) begin
        shadowI_d[k] = coef_i;
        shadowQ_d[k] = coef_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int k = 0; k < 5; k++) begin
        shadowI_q[k] <= (k == 0) ? UNITY : '0;
        shadowQ_q[k] <= '0;
        activeI_q[k] <= (k == 0) ? UNITY : '0;
        activeQ_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 5; k++) begin
        shadowI_q[k] <= shadowI_d[k];
        shadowQ_q[k] <= shadowQ_d[k];
        if (coef_swap) begin
          activeI_q[k] <= shadowI_d[k];
          activeQ_q[k] <= shadowQ_d[k];
        end
      end
    end
  end

  function automatic logic signed [17:0] roundGain(input logic signed [40:0] acc);
    logic signed [41:0] r;
    r = (42'(acc) + 42'sd262144) >>> 19;
    if (r > 42'sd131071)       roundGain = 18'sh1FFFF;
    else if (r < -42'sd131072) roundGain = 18'sh20000;
    else                       roundGain = r[17:0];
  endfunction

  always_comb begin
    accI_d = '0;
    accQ_d = '0;
    for (int k = 0; k < 5; k++) begin
      prodI_d[k] = 38'(activeI_q[k]) * 38'($signed({1'b0, mag[k]}));
      prodQ_d[k] = 38'(activeQ_q[k]) * 38'($signed({1'b0, mag[k]}));
      accI_d     = accI_d + 41'(prodI_q[k]);
      accQ_d     = accQ_d + 41'(prodQ_q[k]);
    end
  end

  // Output rounding/saturation; either rail clipping counts as one event.
  always_comb begin
    sumI = 40'(pII_q) - 40'(pQQ_q);
    sumQ = 40'(pIQ_q) + 40'(pQI_q);
    shI  = (sumI + 40'sd8192) >>> 14;
    shQ  = (sumQ + 40'sd8192) >>> 14;
    satI = (shI > 40'sd524287) || (shI < -40'sd524288);
    satQ = (shQ > 40'sd524287) || (shQ < -40'sd524288);
    yI_d = satI ? (shI[39] ? 20'sh80000 : 20'sh7FFFF) : shI[19:0];
    yQ_d = satQ ? (shQ[39] ? 20'sh80000 : 20'sh7FFFF) : shQ[19:0];
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < SIG_DLY; i++) begin
        dlyI_q[i] <= '0;
        dlyQ_q[i] <= '0;
        dlyV_q[i] <= 1'b0;
      end
      {xI1_q, xQ1_q, xI2_q, xQ2_q, xI3_q, xQ3_q} <= '0;
      {v1_q, v2_q, v3_q, v4_q, outValid_q}       <= '0;
      for (int k = 0; k < 5; k++) begin
        prodI_q[k] <= '0;
        prodQ_q[k] <= '0;
      end
      accI_q   <= '0;
      accQ_q   <= '0;
      gI_q     <= '0;
      gQ_q     <= '0;
      pII_q    <= '0;
      pQQ_q    <= '0;
      pIQ_q    <= '0;
      pQI_q    <= '0;
      yI_q     <= '0;
      yQ_q     <= '0;
      satCnt_q <= '0;
    end else begin
      dlyI_q[0] <= sig_in_i;
      dlyQ_q[0] <= sig_in_q;
      dlyV_q[0] <= in_valid;
      for (int i = 1; i < SIG_DLY; i++) begin
        dlyI_q[i] <= dlyI_q[i-1];
        dlyQ_q[i] <= dlyQ_q[i-1];
        dlyV_q[i] <= dlyV_q[i-1];
      end
      // The sample rides alongside the gain computation until S4 needs it.
      xI1_q <= dlyI_q[SIG_DLY-1];
      xQ1_q <= dlyQ_q[SIG_DLY-1];
      v1_q  <= dlyV_q[SIG_DLY-1];
      xI2_q <= xI1_q;
      xQ2_q <= xQ1_q;
      v2_q  <= v1_q;
      xI3_q <= xI2_q;
      xQ3_q <= xQ2_q;
      v3_q  <= v2_q;
      for (int k = 0; k < 5; k++) begin
        prodI_q[k] <= prodI_d[k];
        prodQ_q[k] <= prodQ_d[k];
      end
      accI_q     <= accI_d;
      accQ_q     <= accQ_d;
      gI_q       <= roundGain(accI_q);
      gQ_q       <= roundGain(accQ_q);
      pII_q      <= 38'(xI3_q) * 38'(gI_q);
      pQQ_q      <= 38'(xQ3_q) * 38'(gQ_q);
      pIQ_q      <= 38'(xI3_q) * 38'(gQ_q);
      pQI_q      <= 38'(xQ3_q) * 38'(gI_q);
      v4_q       <= v3_q;
      yI_q       <= yI_d;
      yQ_q       <= yQ_d;
      outValid_q <= v4_q;
      if (sat_clr)
        satCnt_q <= '0;
      else if ((satI || satQ) && (satCnt_q != 16'hFFFF))
        satCnt_q <= satCnt_q + 16'd1;
    end
  end

  assign sig_out_i = yI_q;
  assign sig_out_q = yQ_q;
  assign out_valid = outValid_q;
  assign sat_cnt   = satCnt_q;

endmodule
